// File: rtl/psc_frame_buf.sv
// psc_frame_buf: store-and-forward frame buffer for the 9-bit psc word stream.
// Words are staged through a one-entry hold register so the "last" flag of a
// word can be decided by what follows it (next SOF or a strobe gap). Frames
// are written speculatively and only become visible to the reader on commit;
// oversize frames, frames that hit a full FIFO and orphan words are dropped.
module psc_frame_buf #(
    parameter int DEPTH   = 32,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [8:0]       iv_data,
    input  logic             i_data_wr,
    output logic [7:0]       ov_data,
    output logic             o_data_valid,
    output logic             o_data_last,
    input  logic             i_data_ready,
    output logic             o_frame_drop,
    output logic [CNT_W-1:0] ov_frame_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO storage: {last, data}
    logic [8:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, cm_ptr_q, rd_ptr_q;
    logic [7:0]       hold_q;   // held word; valid exactly while in RECV
    logic [LW-1:0]    len_q, len_d;
    logic [7:0]       out_data_q;
    logic             out_vld_q, out_last_q, drop_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic in_sof, fifo_full, len_ovf;
    logic push, push_last, drop, hold_load;
    logic rd_load;

    assign in_sof    = iv_data[8];
    assign fifo_full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign len_ovf   = (len_q == LW'(MAX_LEN));
    assign rd_load   = (rd_ptr_q != cm_ptr_q) && (!out_vld_q || i_data_ready);

    // Write FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Write FSM next state; an SOF arriving with a drop still opens a new frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DISCARD: begin
                if (i_data_wr && in_sof) state_d = S_RECV;
            end
            S_RECV: begin
                if (i_data_wr && in_sof)  state_d = S_RECV;
                else if (i_data_wr)       state_d = (len_ovf || fifo_full) ? S_DISCARD : S_RECV;
                else                      state_d = fifo_full ? S_DISCARD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write FSM outputs: push of the held word, drop decision, hold/len update
    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        drop      = 1'b0;
        hold_load = 1'b0;
        len_d     = len_q;
        case (state_q)
            S_IDLE, S_DISCARD: begin
                if (i_data_wr && in_sof) begin
                    hold_load = 1'b1;
                    len_d     = LW'(1);
                end
            end
            S_RECV: begin
                if (i_data_wr && in_sof) begin
                    // new SOF closes the held frame; SOF survives a drop
                    hold_load = 1'b1;
                    len_d     = LW'(1);
                    if (fifo_full) drop = 1'b1;
                    else begin
                        push      = 1'b1;
                        push_last = 1'b1;
                    end
                end else if (i_data_wr) begin
                    if (len_ovf || fifo_full) drop = 1'b1;
                    else begin
                        push      = 1'b1;
                        hold_load = 1'b1;
                        len_d     = len_q + LW'(1);
                    end
                end else begin
                    // strobe gap ends the frame
                    if (fifo_full) drop = 1'b1;
                    else begin
                        push      = 1'b1;
                        push_last = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // FIFO write port (storage needs no reset; pointers gate visibility)
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= {push_last, hold_q};
    end

    // Write side: hold register, frame length, speculative/commit pointers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_q      <= '0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            frame_cnt_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= drop;
            len_q  <= len_d;
            if (hold_load) hold_q <= iv_data[7:0];
            if (drop) begin
                wr_ptr_q <= cm_ptr_q;
            end else if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (push_last) begin
                    cm_ptr_q    <= wr_ptr_q + PW'(1);
                    frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Read side: output register refills whenever empty or being accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else if (rd_load) begin
            {out_last_q, out_data_q} <= mem[rd_ptr_q[AW-1:0]];
            out_vld_q                <= 1'b1;
            rd_ptr_q                 <= rd_ptr_q + PW'(1);
        end else if (i_data_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    assign ov_data      = out_data_q;
    assign o_data_valid = out_vld_q;
    assign o_data_last  = out_last_q;
    assign o_frame_drop = drop_q;
    assign ov_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_psc_frame_buf.sv
// Directed bench for psc_frame_buf: frames in, collected bytes out, compared
// against hand-built expected byte lists.
module tb_psc_frame_buf;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [8:0]  iv_data = '0;
    logic        i_data_wr = 1'b0;
    logic [7:0]  ov_data;
    logic        o_data_valid;
    logic        o_data_last;
    logic        i_data_ready = 1'b0;
    logic        o_frame_drop;
    logic [15:0] ov_frame_cnt;

    psc_frame_buf #(.DEPTH(32), .MAX_LEN(16), .CNT_W(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .iv_data      (iv_data),
        .i_data_wr    (i_data_wr),
        .ov_data      (ov_data),
        .o_data_valid (o_data_valid),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready),
        .o_frame_drop (o_frame_drop),
        .ov_frame_cnt (ov_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    int nvec = 0;
    int nmis = 0;
    int drops = 0;
    logic [8:0] rx[$];
    logic [8:0] exp_q[$];

    // collect accepted bytes and drop pulses mid-cycle
    always @(negedge i_clk) begin
        if (!i_rst && o_data_valid && i_data_ready) rx.push_back({o_data_last, ov_data});
        if (!i_rst && o_frame_drop) drops++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic sof, input logic [7:0] d);
        @(posedge i_clk); #1;
        iv_data   = {sof, d};
        i_data_wr = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_data_wr = 1'b0;
        end
    endtask

    // words first..first+n-1, SOF on the first, no trailing gap
    task automatic send_frame(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_word(i == 0, first + 8'(i));
    endtask

    task automatic exp_frame(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, first + 8'(i)});
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_nbytes"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {23'd0, rx[i]}, {23'd0, exp_q[i]});
        rx.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        #3 i_rst = 1'b1;
        i_data_wr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        rx.delete();
        exp_q.delete();
        drops = 0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk("rst_valid", o_data_valid, 0);
        chk("rst_data",  ov_data, 0);
        chk("rst_last",  o_data_last, 0);
        chk("rst_drop",  o_frame_drop, 0);
        chk("rst_cnt",   ov_frame_cnt, 0);

        // 1: single 16-word frame, ready high
        i_data_ready = 1'b1;
        send_frame(8'h01, 16);
        idle(30);
        exp_frame(8'h01, 16);
        check_rx("t1");
        chk("t1_cnt", ov_frame_cnt, 1);
        chk("t1_drops", drops, 0);

        // 2: two frames back to back
        do_reset();
        i_data_ready = 1'b1;
        send_frame(8'h01, 16);
        send_frame(8'h11, 16);
        idle(40);
        exp_frame(8'h01, 16);
        exp_frame(8'h11, 16);
        check_rx("t2");
        chk("t2_cnt", ov_frame_cnt, 2);
        chk("t2_drops", drops, 0);

        // 3: stalled consumer, third frame overflows the FIFO
        do_reset();
        i_data_ready = 1'b0;
        send_frame(8'h01, 16);
        send_frame(8'h11, 16);
        send_frame(8'h21, 16);
        idle(10);
        chk("t3_stall_valid", o_data_valid, 1);
        chk("t3_stall_data",  ov_data, 8'h01);
        chk("t3_drops", drops, 1);
        chk("t3_cnt_stalled", ov_frame_cnt, 2);
        i_data_ready = 1'b1;
        idle(50);
        exp_frame(8'h01, 16);
        exp_frame(8'h11, 16);
        check_rx("t3");
        chk("t3_cnt", ov_frame_cnt, 2);

        // 4: orphan words then a short frame; also commit/output latency
        do_reset();
        i_data_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(1'b0, 8'h81 + 8'(i));
        send_frame(8'h41, 4);
        idle(1);                       // gap begins
        @(posedge i_clk); #1;          // commit edge
        chk("t4_lat_commit_valid", o_data_valid, 0);
        @(posedge i_clk); #1;
        chk("t4_lat_out_valid", o_data_valid, 1);
        chk("t4_lat_out_data",  ov_data, 8'h41);
        idle(10);
        exp_frame(8'h41, 4);
        check_rx("t4");
        chk("t4_drops", drops, 0);
        chk("t4_cnt", ov_frame_cnt, 1);

        // 5: 17-word frame dropped at word 17, following frame intact
        do_reset();
        i_data_ready = 1'b1;
        send_frame(8'h51, 16);
        send_word(1'b0, 8'h61);
        chk("t5_no_early_drop", drops, 0);
        @(posedge i_clk); #2;
        chk("t5_drop_pulse", o_frame_drop, 1);
        i_data_wr = 1'b0;
        idle(3);
        send_frame(8'h71, 3);
        idle(10);
        exp_frame(8'h71, 3);
        check_rx("t5");
        chk("t5_drops", drops, 1);
        chk("t5_cnt", ov_frame_cnt, 1);

        // 6: reset mid-frame and mid-readout
        do_reset();
        i_data_ready = 1'b0;
        send_frame(8'h01, 4);
        idle(5);
        send_frame(8'hA1, 3);
        chk("t6_pre_valid", o_data_valid, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("t6_async_valid", o_data_valid, 0);
        chk("t6_async_data",  ov_data, 0);
        chk("t6_async_cnt",   ov_frame_cnt, 0);
        i_data_wr = 1'b0;
        @(posedge i_clk); #1 i_rst = 1'b0;
        rx.delete();
        drops = 0;
        i_data_ready = 1'b1;
        idle(5);
        chk("t6_quiet_after_rst", rx.size(), 0);
        send_frame(8'h91, 3);
        idle(10);
        exp_frame(8'h91, 3);
        check_rx("t6");
        chk("t6_cnt", ov_frame_cnt, 1);
        chk("t6_drops", drops, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
